// File: rtl/frost32_mem_access_unit.sv
// Frost32 memory access unit: serves CPU load/store requests from a single-port word RAM without byte
// enables, using read-modify-write for sub-word stores. Define FROST32_MEM_ACCESS_ERR_EN to reject bad accesses.
module frost32_mem_access_unit #(
    parameter int MEM_ADDR_WIDTH = 16,
    parameter int MEM_RD_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cpu_req,
    input  logic [31:0]               cpu_addr,
    input  logic [31:0]               cpu_wdata,
    input  logic                      cpu_access_type,
    input  logic [1:0]                cpu_access_size,
    output logic [31:0]               cpu_rdata,
    output logic                      cpu_ack,
    output logic                      cpu_err,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic                      mem_rd_en,
    output logic                      mem_wr_en,
    output logic [31:0]               mem_wdata,
    input  logic [31:0]               mem_rdata
);
    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, MERGE, WR_ISSUE, ACK} state_t;

    localparam logic [1:0] SIZE_32   = 2'd0;
    localparam logic [1:0] SIZE_16   = 2'd1;
    localparam logic [1:0] SIZE_8    = 2'd2;
    localparam logic [1:0] SIZE_BAD  = 2'd3;
    localparam logic [1:0] WAIT_LOAD = 2'(MEM_RD_LATENCY - 1);

    state_t                    state, state_n;
    logic [1:0]                wait_cnt, wait_cnt_n;
    logic [1:0]                lane, lane_n;
    logic [1:0]                size_q, size_n;
    logic                      write_q, write_n;
    logic [15:0]               wdata_q, wdata_n;
    logic [31:0]               word_q, word_n;
    logic [31:0]               cpu_rdata_n;
    logic                      cpu_ack_n;
    logic                      cpu_err_n;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr_n;
    logic                      mem_rd_en_n;
    logic                      mem_wr_en_n;
    logic [31:0]               mem_wdata_n;
    logic                      req_err;
    logic [1:0]                req_size;

    assign req_size = (cpu_access_size == SIZE_BAD) ? SIZE_32 : cpu_access_size;

`ifdef FROST32_MEM_ACCESS_ERR_EN
    assign req_err = (cpu_access_size == SIZE_BAD)
                  || ((cpu_access_size == SIZE_16) && cpu_addr[0])
                  || ((cpu_access_size == SIZE_32) && (cpu_addr[1:0] != 2'b00))
                  || ((cpu_addr >> (MEM_ADDR_WIDTH + 2)) != 32'd0);
`else
    // Without checking, upper address bits are simply dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^cpu_addr[31:MEM_ADDR_WIDTH+2];
    assign req_err = 1'b0;
`endif

    function automatic logic [31:0] lane_extract(input logic [31:0] w, input logic [1:0] size,
                                                 input logic [1:0] sel);
        logic [31:0] r;
        case (size)
            SIZE_16: r = {16'h0, sel[1] ? w[31:16] : w[15:0]};
            SIZE_8: begin
                case (sel)
                    2'd0:    r = {24'h0, w[7:0]};
                    2'd1:    r = {24'h0, w[15:8]};
                    2'd2:    r = {24'h0, w[23:16]};
                    default: r = {24'h0, w[31:24]};
                endcase
            end
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] w, input logic [15:0] d,
                                               input logic [1:0] size, input logic [1:0] sel);
        logic [31:0] r;
        r = w;
        if (size == SIZE_16) begin
            if (sel[1]) r[31:16] = d;
            else        r[15:0]  = d;
        end else begin
            case (sel)
                2'd0:    r[7:0]   = d[7:0];
                2'd1:    r[15:8]  = d[7:0];
                2'd2:    r[23:16] = d[7:0];
                default: r[31:24] = d[7:0];
            endcase
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= 2'd0;
            lane      <= 2'd0;
            size_q    <= 2'd0;
            write_q   <= 1'b0;
            wdata_q   <= 16'h0;
            word_q    <= 32'h0;
            cpu_rdata <= 32'h0;
            cpu_ack   <= 1'b0;
            cpu_err   <= 1'b0;
            mem_addr  <= '0;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_wdata <= 32'h0;
        end else begin
            state     <= state_n;
            wait_cnt  <= wait_cnt_n;
            lane      <= lane_n;
            size_q    <= size_n;
            write_q   <= write_n;
            wdata_q   <= wdata_n;
            word_q    <= word_n;
            cpu_rdata <= cpu_rdata_n;
            cpu_ack   <= cpu_ack_n;
            cpu_err   <= cpu_err_n;
            mem_addr  <= mem_addr_n;
            mem_rd_en <= mem_rd_en_n;
            mem_wr_en <= mem_wr_en_n;
            mem_wdata <= mem_wdata_n;
        end
    end

    // Outputs are computed one cycle ahead so each strobe is registered and lines up with its state.
    always_comb begin
        state_n     = state;
        wait_cnt_n  = wait_cnt;
        lane_n      = lane;
        size_n      = size_q;
        write_n     = write_q;
        wdata_n     = wdata_q;
        word_n      = word_q;
        cpu_rdata_n = cpu_rdata;
        cpu_ack_n   = 1'b0;
        cpu_err_n   = cpu_err;
        mem_addr_n  = mem_addr;
        mem_rd_en_n = 1'b0;
        mem_wr_en_n = 1'b0;
        mem_wdata_n = mem_wdata;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    lane_n  = cpu_addr[1:0];
                    size_n  = req_size;
                    write_n = cpu_access_type;
                    wdata_n = cpu_wdata[15:0];
                    if (req_err) begin
                        state_n     = ACK;
                        cpu_ack_n   = 1'b1;
                        cpu_err_n   = 1'b1;
                        cpu_rdata_n = 32'h0;
                    end else begin
                        mem_addr_n = cpu_addr[MEM_ADDR_WIDTH+1:2];
                        if (cpu_access_type && (req_size == SIZE_32)) begin
                            state_n     = WR_ISSUE;
                            mem_wr_en_n = 1'b1;
                            mem_wdata_n = cpu_wdata;
                        end else begin
                            state_n     = RD_ISSUE;
                            mem_rd_en_n = 1'b1;
                        end
                    end
                end
            end
            RD_ISSUE: begin
                state_n    = RD_WAIT;
                wait_cnt_n = WAIT_LOAD;
            end
            RD_WAIT: begin
                if (wait_cnt == 2'd0) begin
                    word_n = mem_rdata;
                    if (write_q) begin
                        state_n = MERGE;
                    end else begin
                        state_n     = ACK;
                        cpu_ack_n   = 1'b1;
                        cpu_err_n   = 1'b0;
                        cpu_rdata_n = lane_extract(mem_rdata, size_q, lane);
                    end
                end else begin
                    wait_cnt_n = wait_cnt - 2'd1;
                end
            end
            MERGE: begin
                state_n     = WR_ISSUE;
                mem_wr_en_n = 1'b1;
                mem_wdata_n = lane_merge(word_q, wdata_q, size_q, lane);
            end
            WR_ISSUE: begin
                state_n     = ACK;
                cpu_ack_n   = 1'b1;
                cpu_err_n   = 1'b0;
                cpu_rdata_n = 32'h0;
            end
            ACK:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
endmodule
